// File: rtl/ws2812_pkg.sv
// Shared WS2812B definitions: bit-generator state encoding, 100 MHz timing defaults
// and frame geometry used by the bit generator, rotation counter and bit register.
package ws2812_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HIGH,
      ST_LOW,
      ST_LATCH
   } state_t;

   localparam int unsigned CLK_MHZ  = 100;
   localparam int unsigned T0H_NS   = 400;
   localparam int unsigned T1H_NS   = 800;
   localparam int unsigned BIT_NS   = 1250;
   localparam int unsigned LATCH_NS = 50_000;

   function automatic int unsigned ns_to_cycles(input int unsigned ns);
      return (ns * CLK_MHZ) / 1000;
   endfunction

   localparam int unsigned T0H_CYCLES_DEF   = ns_to_cycles(T0H_NS);
   localparam int unsigned T1H_CYCLES_DEF   = ns_to_cycles(T1H_NS);
   localparam int unsigned BIT_CYCLES_DEF   = ns_to_cycles(BIT_NS);
   localparam int unsigned LATCH_CYCLES_DEF = ns_to_cycles(LATCH_NS);
   localparam int unsigned CNT_W_DEF        = 13;

   localparam int unsigned BITS_PER_LED = 24;
   localparam int unsigned LED_COUNT    = 4;
   localparam int unsigned FRAME_BITS   = BITS_PER_LED * LED_COUNT;

endpackage

// File: rtl/ws2812_phase_timer.sv
// Loadable phase counter; flags when the count equals the terminal value
// selected by the owning FSM for the current phase.
module ws2812_phase_timer
   import ws2812_pkg::*;
#(
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] terminal,
   output logic             done
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= '0;
      end else begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = (count == terminal);

endmodule

// File: rtl/ws2812_bit_gen.sv
// WS2812B single-wire bit generator: emits one high/low bit per start, pulses
// genDone at each bit end and after the frame latch low period.
module ws2812_bit_gen
   import ws2812_pkg::*;
#(
   parameter int unsigned T0H_CYCLES   = T0H_CYCLES_DEF,
   parameter int unsigned T1H_CYCLES   = T1H_CYCLES_DEF,
   parameter int unsigned BIT_CYCLES   = BIT_CYCLES_DEF,
   parameter int unsigned LATCH_CYCLES = LATCH_CYCLES_DEF,
   parameter int unsigned CNT_W        = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic sendEn,
   input  logic dataBit,
   input  logic frameDone,
   output logic dout,
   output logic genDone,
   output logic busy
);

   if (T0H_CYCLES == 0 || T0H_CYCLES >= BIT_CYCLES - 1 ||
       T1H_CYCLES == 0 || T1H_CYCLES >= BIT_CYCLES - 1 ||
       LATCH_CYCLES == 0 ||
       longint'(LATCH_CYCLES) > (longint'(1) << CNT_W)) begin : g_bad_params
      $error("ws2812_bit_gen: illegal timing parameters for CNT_W");
   end

   // LOW lasts BIT-TH-1 cycles so HIGH + LOW + the IDLE start cycle make one bit period
   localparam logic [CNT_W-1:0] T0H_TERM   = CNT_W'(T0H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T1H_TERM   = CNT_W'(T1H_CYCLES - 1);
   localparam logic [CNT_W-1:0] T0L_TERM   = CNT_W'(BIT_CYCLES - T0H_CYCLES - 2);
   localparam logic [CNT_W-1:0] T1L_TERM   = CNT_W'(BIT_CYCLES - T1H_CYCLES - 2);
   localparam logic [CNT_W-1:0] LATCH_TERM = CNT_W'(LATCH_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   logic             bit_reg;
   logic             bit_load;
   logic             cnt_load;
   logic             cnt_done;
   logic [CNT_W-1:0] cnt_term;

   ws2812_phase_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .terminal (cnt_term),
      .done     (cnt_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         bit_reg <= 1'b0;
         dout    <= 1'b0;
      end else begin
         state <= state_next;
         dout  <= (state_next == ST_HIGH);
         if (bit_load) begin
            bit_reg <= dataBit;
         end
      end
   end

   always_comb begin
      state_next = state;
      cnt_load   = 1'b0;
      bit_load   = 1'b0;
      cnt_term   = '0;
      case (state)
         ST_IDLE: begin
            cnt_load = 1'b1;
            if (frameDone) begin
               state_next = ST_LATCH;
            end else if (sendEn) begin
               state_next = ST_HIGH;
               bit_load   = 1'b1;
            end
         end
         ST_HIGH: begin
            cnt_term = bit_reg ? T1H_TERM : T0H_TERM;
            if (cnt_done) begin
               state_next = ST_LOW;
               cnt_load   = 1'b1;
            end
         end
         ST_LOW: begin
            cnt_term = bit_reg ? T1L_TERM : T0L_TERM;
            if (cnt_done) begin
               state_next = ST_IDLE;
               cnt_load   = 1'b1;
            end
         end
         ST_LATCH: begin
            cnt_term = LATCH_TERM;
            if (cnt_done) begin
               state_next = ST_IDLE;
               cnt_load   = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
            cnt_load   = 1'b1;
         end
      endcase
   end

   assign genDone = cnt_done && ((state == ST_LOW) || (state == ST_LATCH));
   assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_ws2812_bit_gen.sv
// Directed bench for ws2812_bit_gen: bit timing, streaming, latch, full frame,
// asynchronous reset and mid-bit sendEn drop.
module tb_ws2812_bit_gen;

   logic clk = 1'b0;
   logic reset;
   logic sendEn;
   logic dataBit;
   logic frameDone;
   logic dout;
   logic genDone;
   logic busy;

   int checks   = 0;
   int failures = 0;

   ws2812_bit_gen #(
      .T0H_CYCLES   (40),
      .T1H_CYCLES   (80),
      .BIT_CYCLES   (125),
      .LATCH_CYCLES (5000),
      .CNT_W        (13)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sendEn    (sendEn),
      .dataBit   (dataBit),
      .frameDone (frameDone),
      .dout      (dout),
      .genDone   (genDone),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Samples n negedges after a start; drops sendEn after sample drop_at and
   // optionally toggles dataBit every cycle (it must be ignored mid-bit).
   task automatic observe(input int n, input int drop_at, input bit flip,
                          output int hc, output int fh, output int lh,
                          output int gc, output int gp, output int bc);
      hc = 0; fh = 0; lh = 0; gc = 0; gp = 0; bc = 0;
      for (int k = 1; k <= n; k++) begin
         @(negedge clk);
         if (dout) begin
            hc++;
            if (fh == 0) fh = k;
            lh = k;
         end
         if (genDone) begin
            gc++;
            gp = k;
         end
         if (busy) bc++;
         if (k == drop_at) sendEn = 1'b0;
         if (flip) dataBit = ~dataBit;
      end
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1; sendEn = 1'b0; dataBit = 1'b0; frameDone = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL reset_dout actual=%b required=0", dout); end
      checks++; if (genDone !== 1'b0) begin failures++; $display("FAIL reset_gendone actual=%b required=0", genDone); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
      reset = 1'b0;
      bad = 0;
      repeat (5) begin
         @(negedge clk);
         if (dout !== 1'b0 || genDone !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL idle_quiet actual=%0d_active_cycles required=0", bad); end
   endtask

   task automatic test_one_bit();
      int hc, fh, lh, gc, gp, bc;
      @(negedge clk); dataBit = 1'b1; sendEn = 1'b1;
      observe(130, 1, 1'b0, hc, fh, lh, gc, gp, bc);
      checks++; if (hc != 80) begin failures++; $display("FAIL one_high_cycles actual=%0d required=80", hc); end
      checks++; if (fh != 1) begin failures++; $display("FAIL one_first_high actual=%0d required=1", fh); end
      checks++; if (lh != 80) begin failures++; $display("FAIL one_last_high actual=%0d required=80", lh); end
      checks++; if (gc != 1) begin failures++; $display("FAIL one_gendone_count actual=%0d required=1", gc); end
      checks++; if (gp != 124) begin failures++; $display("FAIL one_gendone_pos actual=%0d required=124", gp); end
      checks++; if (bc != 124) begin failures++; $display("FAIL one_busy_cycles actual=%0d required=124", bc); end
   endtask

   task automatic test_zero_bit();
      int hc, fh, lh, gc, gp, bc;
      @(negedge clk); dataBit = 1'b0; sendEn = 1'b1;
      observe(130, 1, 1'b1, hc, fh, lh, gc, gp, bc);
      checks++; if (hc != 40) begin failures++; $display("FAIL zero_high_cycles actual=%0d required=40", hc); end
      checks++; if (lh != 40) begin failures++; $display("FAIL zero_last_high actual=%0d required=40", lh); end
      checks++; if (gc != 1) begin failures++; $display("FAIL zero_gendone_count actual=%0d required=1", gc); end
      checks++; if (gp != 124) begin failures++; $display("FAIL zero_gendone_pos actual=%0d required=124", gp); end
      checks++; if (bc != 124) begin failures++; $display("FAIL zero_busy_cycles actual=%0d required=124", bc); end
   endtask

   task automatic test_stream();
      int rise[5];
      int width[5];
      int exp_w[5];
      int nr, nw, gd, run;
      bit prev;
      exp_w = '{80, 40, 80, 40, 80};
      rise = '{0, 0, 0, 0, 0};
      width = '{0, 0, 0, 0, 0};
      nr = 0; nw = 0; gd = 0; run = 0; prev = 1'b0;
      @(negedge clk); dataBit = 1'b1; sendEn = 1'b1;
      for (int k = 1; k <= 5 * 125 + 10; k++) begin
         @(negedge clk);
         if (dout && !prev) begin
            if (nr < 5) rise[nr] = k;
            nr++;
         end
         if (dout) run++;
         if (!dout && prev) begin
            if (nw < 5) width[nw] = run;
            nw++;
            run = 0;
         end
         prev = dout;
         if (genDone) begin
            gd++;
            dataBit = ~dataBit;
            if (gd == 5) sendEn = 1'b0;
         end
      end
      checks++; if (nr != 5) begin failures++; $display("FAIL stream_rises actual=%0d required=5", nr); end
      checks++; if (gd != 5) begin failures++; $display("FAIL stream_gendones actual=%0d required=5", gd); end
      checks++; if (rise[0] != 1) begin failures++; $display("FAIL stream_first_rise actual=%0d required=1", rise[0]); end
      for (int i = 1; i < 5; i++) begin
         checks++;
         if (rise[i] - rise[i-1] != 125) begin
            failures++; $display("FAIL stream_period_%0d actual=%0d required=125", i, rise[i] - rise[i-1]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (width[i] != exp_w[i]) begin
            failures++; $display("FAIL stream_width_%0d actual=%0d required=%0d", i, width[i], exp_w[i]);
         end
      end
   endtask

   task automatic test_latch();
      int lat_high, lat_busy, fh, gc, g1, g2;
      logic busy_after;
      lat_high = 0; lat_busy = 0; fh = 0; gc = 0; g1 = 0; g2 = 0; busy_after = 1'bx;
      @(negedge clk); frameDone = 1'b1; sendEn = 1'b1; dataBit = 1'b0;
      for (int k = 1; k <= 5140; k++) begin
         @(negedge clk);
         if (k <= 5000) begin
            if (dout) lat_high++;
            if (busy) lat_busy++;
         end
         if (k == 5001) busy_after = busy;
         if (dout && fh == 0) fh = k;
         if (genDone) begin
            gc++;
            if (gc == 1) begin g1 = k; frameDone = 1'b0; dataBit = 1'b1; end
            if (gc == 2) begin g2 = k; sendEn = 1'b0; end
         end
      end
      checks++; if (lat_high != 0) begin failures++; $display("FAIL latch_dout_high actual=%0d required=0", lat_high); end
      checks++; if (lat_busy != 5000) begin failures++; $display("FAIL latch_busy actual=%0d required=5000", lat_busy); end
      checks++; if (g1 != 5000) begin failures++; $display("FAIL latch_gendone_pos actual=%0d required=5000", g1); end
      checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL latch_idle_after actual=%b required=0", busy_after); end
      checks++; if (fh != 5002) begin failures++; $display("FAIL latch_next_bit_start actual=%0d required=5002", fh); end
      checks++; if (g2 != 5125) begin failures++; $display("FAIL latch_next_bit_done actual=%0d required=5125", g2); end
      checks++; if (gc != 2) begin failures++; $display("FAIL latch_gendone_count actual=%0d required=2", gc); end
   endtask

   task automatic test_frame();
      int cnt, gc, latch_pos, last_bit_pos, hi, exp_hi, tail_high;
      cnt = 0; gc = 0; latch_pos = 0; last_bit_pos = 0; hi = 0; tail_high = 0;
      exp_hi = 0;
      for (int i = 0; i < 96; i++) exp_hi += (i % 3 == 0) ? 80 : 40;
      @(negedge clk); frameDone = 1'b0; dataBit = 1'b1; sendEn = 1'b1;
      for (int k = 1; k <= 17020; k++) begin
         @(negedge clk);
         if (dout) begin
            if (k <= 17000) hi++;
            else tail_high++;
         end
         if (genDone) begin
            gc++;
            if (cnt == 96) begin
               latch_pos = k; cnt = 0; sendEn = 1'b0;
            end else begin
               cnt++;
               if (cnt == 96) last_bit_pos = k;
            end
            frameDone = (cnt == 96);
            dataBit = (cnt % 3 == 0);
         end
      end
      frameDone = 1'b0;
      checks++; if (gc != 97) begin failures++; $display("FAIL frame_gendones actual=%0d required=97", gc); end
      checks++; if (last_bit_pos != 11999) begin failures++; $display("FAIL frame_last_bit_pos actual=%0d required=11999", last_bit_pos); end
      checks++; if (latch_pos != 17000) begin failures++; $display("FAIL frame_latch_pos actual=%0d required=17000", latch_pos); end
      checks++; if (cnt != 0) begin failures++; $display("FAIL frame_model_wrap actual=%0d required=0", cnt); end
      checks++; if (hi != exp_hi) begin failures++; $display("FAIL frame_high_cycles actual=%0d required=%0d", hi, exp_hi); end
      checks++; if (tail_high != 0) begin failures++; $display("FAIL frame_tail_dout actual=%0d required=0", tail_high); end
   endtask

   task automatic test_async_reset();
      int hc, fh, lh, gc, gp, bc;
      @(negedge clk); dataBit = 1'b1; sendEn = 1'b1;
      repeat (20) @(negedge clk);
      checks++; if (dout !== 1'b1) begin failures++; $display("FAIL areset_pre_high actual=%b required=1", dout); end
      #2 reset = 1'b1;
      #1;
      checks++; if (dout !== 1'b0) begin failures++; $display("FAIL areset_dout actual=%b required=0", dout); end
      checks++; if (genDone !== 1'b0) begin failures++; $display("FAIL areset_gendone actual=%b required=0", genDone); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL areset_busy actual=%b required=0", busy); end
      repeat (2) @(negedge clk);
      reset = 1'b0; dataBit = 1'b1; sendEn = 1'b1;
      observe(130, 1, 1'b0, hc, fh, lh, gc, gp, bc);
      checks++; if (hc != 80 || fh != 1) begin failures++; $display("FAIL areset_restart_high actual=%0d@%0d required=80@1", hc, fh); end
      checks++; if (gc != 1 || gp != 124) begin failures++; $display("FAIL areset_restart_done actual=%0d@%0d required=1@124", gc, gp); end
   endtask

   task automatic test_drop();
      int hc, fh, lh, gc, gp, bc;
      @(negedge clk); dataBit = 1'b1; sendEn = 1'b1;
      observe(300, 10, 1'b1, hc, fh, lh, gc, gp, bc);
      checks++; if (hc != 80 || lh != 80) begin failures++; $display("FAIL drop_high actual=%0d_last=%0d required=80_last=80", hc, lh); end
      checks++; if (gc != 1) begin failures++; $display("FAIL drop_gendone_count actual=%0d required=1", gc); end
      checks++; if (gp != 124) begin failures++; $display("FAIL drop_gendone_pos actual=%0d required=124", gp); end
      checks++; if (bc != 124) begin failures++; $display("FAIL drop_busy_cycles actual=%0d required=124", bc); end
   endtask

   initial begin
      test_reset();
      test_one_bit();
      test_zero_bit();
      test_stream();
      test_latch();
      test_frame();
      test_async_reset();
      test_drop();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ws2812_bit_gen.md
Name: ws2812_bit_gen

Overview:
Serial waveform generator for the WS2812B LED chain. Consumes one data bit at a time from the rotating bit register and drives the single-wire `dout` line with WS2812B high/low timing. Pulses `genDone` once per completed bit, which advances the downstream 96-bit rotation counter and rotates the bit register. When the counter reports `frameDone`, it inserts the >50 us latch (reset) low period. Targets the 100 MHz board clock.

Parameters:
- T0H_CYCLES, 40, high time for a '0' bit (0.40 us)
- T1H_CYCLES, 80, high time for a '1' bit (0.80 us)
- BIT_CYCLES, 125, total bit period including the IDLE decision cycle (1.25 us)
- LATCH_CYCLES, 5000, latch low period (50 us)
- CNT_W, 13, phase counter width; must hold LATCH_CYCLES-1

Ports:
- clk, input, 1, system clock (100 MHz)
- reset, input, 1, asynchronous, active-high reset
- sendEn, input, 1, frame transmission enabled; start a new bit when idle
- dataBit, input, 1, current bit from the rotating register; sampled only on a bit start
- frameDone, input, 1, downstream counter reports 96 bits sent; held high until one further genDone
- dout, output, 1, WS2812B data line
- genDone, output, 1, one-cycle pulse at bit completion and at latch completion
- busy, output, 1, high in HIGH, LOW or LATCH

Behaviour:
- Reset (asynchronous, effective immediately): state=IDLE, counter=0, bitReg=0, dout=0, genDone=0, busy=0.
- States: IDLE, HIGH, LOW, LATCH. Registered state, counter and dout.
- IDLE:
  - dout=0.
  - If frameDone=1: go to LATCH, counter=0. frameDone has priority over sendEn.
  - Else if sendEn=1: bitReg<=dataBit, go to HIGH, counter=0.
  - Else stay in IDLE.
- HIGH:
  - dout=1 for TH cycles, where TH = bitReg ? T1H_CYCLES : T0H_CYCLES.
  - At counter==TH-1: go to LOW, counter=0.
- LOW:
  - dout=0 for BIT_CYCLES-TH-1 cycles.
  - genDone=1 during the last LOW cycle (decoded from registered state==LOW and counter terminal value; never asserted elsewhere in LOW).
  - Then go to IDLE.
- Bit period: HIGH + LOW + one IDLE cycle = exactly BIT_CYCLES when sendEn stays high. Back-to-back bits have no extra gap.
- LATCH:
  - dout=0 for LATCH_CYCLES cycles.
  - genDone=1 during the last LATCH cycle. This pulse acknowledges the frame so the downstream counter leaves its terminal count.
  - Then go to IDLE.
- Downstream state is updated on the same edge that ends the genDone cycle. The following IDLE cycle therefore sees the updated frameDone and the rotated dataBit.
- sendEn deasserted mid-bit: the current bit completes fully, including its genDone; then remain in IDLE. Bits are never truncated.
- sendEn deasserted while frameDone=1: LATCH still runs, so the chain always latches a completed frame.
- dataBit changes outside the IDLE start cycle: ignored (bitReg holds).
- Counter arithmetic is unsigned CNT_W bits. It is compared against parameter-minus-1 terminal values and never wraps in normal operation.
- Illegal parameters (T1H_CYCLES >= BIT_CYCLES-1, or LATCH_CYCLES > 2^CNT_W) are flagged by an elaboration-time check.

Decomposition:
- Shared package ws2812_pkg: state encoding, default timing constants derived from a 100 MHz clock, and bits-per-LED (24) / LED-count constants shared with the counter and bit register.
- One natural sub-module, ws2812_phase_timer:
  - loadable CNT_W up-counter with a terminal-value input and a terminal-count flag
  - reused by the FSM for the HIGH, LOW and LATCH phases.

Test Plan:
- Single '1' bit, sendEn pulse for one cycle while IDLE: dout high exactly 80 cycles, low 44 cycles, genDone one cycle on the 124th cycle after start, then IDLE with dout=0.
- Single '0' bit: dout high 40 cycles, low 84 cycles, genDone on the 124th cycle; streaming alternating 1/0 with sendEn held gives rising edges of dout exactly 125 cycles apart.
- frameDone=1 and sendEn=1 together in IDLE: LATCH taken, dout low 5000 cycles, single genDone on the last cycle, busy=1 throughout, then the next bit starts once frameDone=0.
- Full frame with a behavioural 96-count model: 96 bit genDones, then one latch genDone; model wraps to 0; total frame = 96*125+1+5000 cycles from first start.
- Assert reset asynchronously mid-HIGH (between clock edges): dout falls before the next clk edge; genDone=0, busy=0; after release with sendEn=1 a fresh bit starts with full timing.
- Drop sendEn at cycle 10 of a '1' bit: full 80/44 waveform completes, genDone fires once, then dout stays 0 and no further genDone occurs.
